// File: rtl/lif_spike_collector.sv
// lif_spike_collector: round-robin capture of per-lane LIF spikes into a timestamped AER event FIFO
module lif_spike_collector #(
  parameter int NUM_LANES   = 4,
  parameter int NEURON_ID_W = 4,
  parameter int TS_W        = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int DROP_W      = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             scan_start_en,
  input  logic [NUM_LANES-1:0]             spike_in,
  input  logic [NUM_LANES*NEURON_ID_W-1:0] spike_id_in,
  output logic                             ev_valid,
  input  logic                             ev_ready,
  output logic [NEURON_ID_W-1:0]           ev_id,
  output logic [TS_W-1:0]                  ev_ts,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic [DROP_W-1:0]                drop_cnt,
  output logic                             overflow
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [TS_W-1:0]        r_ts;
  logic [NUM_LANES-1:0]   r_pend;
  logic [NEURON_ID_W-1:0] r_hid [NUM_LANES];
  logic [TS_W-1:0]        r_hts [NUM_LANES];
  logic [LW-1:0]          r_ptr;
  logic [NEURON_ID_W-1:0] r_mid [FIFO_DEPTH];
  logic [TS_W-1:0]        r_mts [FIFO_DEPTH];
  logic [AW-1:0]          r_wp, r_rp;
  logic [AW:0]            r_cnt;
  logic [DROP_W-1:0]      r_drop;
  logic                   r_ovf;
  logic [2*NUM_LANES-1:0] w_rot;
  logic                   w_any, w_pop, w_push;
  logic [LW-1:0]          w_off, w_gidx, w_ptr_nxt;
  logic [LW:0]            w_sum;
  logic [NUM_LANES-1:0]   w_gnt, w_drop;
  logic [DROP_W:0]        w_dsum;
  // Rotating the pending flags so the search start lands at bit 0 turns round-robin into a priority encode.
  always_comb w_rot = {r_pend, r_pend} >> r_ptr;
  always_comb begin
    w_any = 1'b0;
    w_off = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--)
      if (w_rot[k]) begin
        w_any = 1'b1;
        w_off = LW'(k);
      end
  end
  always_comb begin
    w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    w_gidx    = (w_sum >= (LW+1)'(NUM_LANES)) ? LW'(w_sum - (LW+1)'(NUM_LANES)) : w_sum[LW-1:0];
    w_ptr_nxt = (w_gidx == LW'(NUM_LANES - 1)) ? '0 : w_gidx + 1'b1;
    w_pop     = (r_cnt != '0) && ev_ready;
    w_push    = w_any && ((r_cnt != (AW+1)'(FIFO_DEPTH)) || w_pop);
    w_gnt     = w_push ? (NUM_LANES'(1) << w_gidx) : '0;
    w_drop    = spike_in & r_pend & ~w_gnt;
  end
  always_comb begin
    w_dsum = {1'b0, r_drop};
    for (int k = 0; k < NUM_LANES; k++)
      w_dsum = w_dsum + (DROP_W+1)'(w_drop[k]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts   <= '0;
      r_pend <= '0;
      r_ptr  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_drop <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_hid[i] <= '0;
        r_hts[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mid[i] <= '0;
        r_mts[i] <= '0;
      end
    end else begin
      if (scan_start_en) r_ts <= r_ts + 1'b1;
      for (int i = 0; i < NUM_LANES; i++)
        if (spike_in[i] && !w_drop[i]) begin
          r_pend[i] <= 1'b1;
          r_hid[i]  <= spike_id_in[i*NEURON_ID_W +: NEURON_ID_W];
          r_hts[i]  <= r_ts;
        end else if (w_gnt[i]) begin
          r_pend[i] <= 1'b0;
        end
      if (w_push) begin
        r_mid[r_wp] <= r_hid[w_gidx];
        r_mts[r_wp] <= r_hts[w_gidx];
        r_wp        <= r_wp + 1'b1;
        r_ptr       <= w_ptr_nxt;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt  <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_drop <= w_dsum[DROP_W] ? '1 : w_dsum[DROP_W-1:0];
      if (|w_drop) r_ovf <= 1'b1;
    end
  end
  always_comb begin
    ev_valid   = r_cnt != '0;
    ev_id      = r_mid[r_rp];
    ev_ts      = r_mts[r_rp];
    fifo_count = r_cnt;
    drop_cnt   = r_drop;
    overflow   = r_ovf;
  end
endmodule

// File: tb/tb_lif_spike_collector.sv
// tb_lif_spike_collector: directed and random checks of the spike collector against a queue-based model
module tb_lif_spike_collector;
  localparam int N = 4, IW = 4, TW = 8, D = 8, DW = 8;
  logic clk = 1'b0, rst_n = 1'b0, scan = 1'b0, rdy = 1'b0;
  logic [N-1:0] spk = '0;
  logic [N*IW-1:0] ids = '0;
  logic ev_valid, overflow;
  logic [IW-1:0] ev_id;
  logic [TW-1:0] ev_ts;
  logic [$clog2(D):0] fifo_count;
  logic [DW-1:0] drop_cnt;
  lif_spike_collector #(.NUM_LANES(N), .NEURON_ID_W(IW), .TS_W(TW), .FIFO_DEPTH(D), .DROP_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .scan_start_en(scan), .spike_in(spk), .spike_id_in(ids),
    .ev_valid(ev_valid), .ev_ready(rdy), .ev_id(ev_id), .ev_ts(ev_ts),
    .fifo_count(fifo_count), .drop_cnt(drop_cnt), .overflow(overflow));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  typedef struct {int id; int ts;} ev_t;
  ev_t mq[$];
  int m_ts, m_ptr, m_drop;
  bit m_ovf;
  bit m_pend[N];
  int m_hid[N], m_hts[N];
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    mq.delete();
    m_ts = 0; m_ptr = 0; m_drop = 0; m_ovf = 0;
    for (int i = 0; i < N; i++) m_pend[i] = 0;
  endtask
  task automatic m_update();
    int g;
    bit pop;
    pop = mq.size() > 0 && rdy;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    if (mq.size() == D && !pop) g = -1;
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      mq.push_back('{m_hid[g], m_hts[g]});
      m_pend[g] = 0;
      m_ptr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++)
      if (spk[i]) begin
        if (m_pend[i]) begin
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
          m_ovf = 1;
        end else begin
          m_pend[i] = 1;
          m_hid[i] = int'(ids[i*IW +: IW]);
          m_hts[i] = m_ts;
        end
      end
    if (scan) m_ts = (m_ts + 1) % 256;
  endtask
  task automatic compare();
    chk("ev_valid", int'(ev_valid), int'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("ev_id", int'(ev_id), mq[0].id);
      chk("ev_ts", int'(ev_ts), mq[0].ts);
    end
    chk("fifo_count", int'(fifo_count), mq.size());
    chk("drop_cnt", int'(drop_cnt), m_drop);
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask
  task automatic step(input logic [N-1:0] s, input logic [N*IW-1:0] d, input logic sc, input logic r);
    spk = s; ids = d; scan = sc; rdy = r;
    m_update();
    @(posedge clk);
    #1;
    compare();
  endtask
  task automatic idle(input int n, input logic r);
    repeat (n) step('0, '0, 1'b0, r);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; spk = '0; scan = 1'b0; rdy = 1'b0;
    m_reset();
    #1;
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_id", int'(ev_id), 0);
    chk("rst_ts", int'(ev_ts), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic fill_round(input int r);
    logic [N*IW-1:0] d;
    for (int i = 0; i < N; i++) d[i*IW +: IW] = IW'(4 * r + i);
    step('1, d, 1'b0, 1'b0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int got;
    bit seen3, seen9;
    @(posedge clk);
    #1;
    do_reset();
    // single spike: lane 2, id 5, timestep 3
    repeat (3) step('0, '0, 1'b1, 1'b1);
    step(4'b0100, 16'h0500, 1'b0, 1'b1);
    chk("t1_lat1", int'(ev_valid), 0);
    idle(1, 1'b1);
    chk("t1_valid", int'(ev_valid), 1);
    chk("t1_id", int'(ev_id), 5);
    chk("t1_ts", int'(ev_ts), 3);
    idle(1, 1'b1);
    chk("t1_gone", int'(ev_valid), 0);
    // all lanes together
    do_reset();
    step(4'hF, 16'h4321, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      idle(1, 1'b1);
      chk("t2_order", int'(ev_id), k + 1);
    end
    chk("t2_drop", int'(drop_cnt), 0);
    idle(2, 1'b1);
    // fairness: lane 1 granted last, then lanes 0 and 3 pending
    step(4'b0010, 16'h0070, 1'b0, 1'b1);
    idle(3, 1'b1);
    step(4'b1001, 16'hA00B, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("t3_first", int'(ev_id), 10);
    idle(1, 1'b1);
    chk("t3_second", int'(ev_id), 11);
    idle(2, 1'b1);
    // back-pressure: 12 spikes, 8 queued, 4 pending
    do_reset();
    for (int r = 0; r < 3; r++) begin
      fill_round(r);
      if (r < 2) idle(4, 1'b0);
    end
    idle(2, 1'b0);
    chk("t4_full", int'(fifo_count), 8);
    got = 0;
    for (int c = 0; c < 40 && got < 12; c++) begin
      if (ev_valid) begin
        chk("t4_drain", int'(ev_id), got);
        got++;
      end
      step('0, '0, 1'b0, 1'b1);
    end
    chk("t4_total", got, 12);
    chk("t4_drop", int'(drop_cnt), 0);
    // collision on a held lane while the FIFO is full
    do_reset();
    fill_round(0); idle(4, 1'b0);
    fill_round(1); idle(4, 1'b0);
    step(4'b0001, 16'h0003, 1'b0, 1'b0);
    step(4'b0001, 16'h0009, 1'b0, 1'b0);
    chk("t5_drop", int'(drop_cnt), 1);
    chk("t5_ovf", int'(overflow), 1);
    got = 0; seen3 = 0; seen9 = 0;
    for (int c = 0; c < 40 && got < 9; c++) begin
      if (ev_valid) begin
        got++;
        if (ev_id == 4'h3 && got == 9) seen3 = 1;
        if (ev_id == 4'h9) seen9 = 1;
      end
      step('0, '0, 1'b0, 1'b1);
    end
    chk("t5_total", got, 9);
    chk("t5_held_out", int'(seen3), 1);
    chk("t5_dropped_out", int'(seen9), 0);
    // timestep wrap and coincident scan
    do_reset();
    repeat (256) step('0, '0, 1'b1, 1'b0);
    step(4'b0010, 16'h0060, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("t6_wrap_ts", int'(ev_ts), 0);
    chk("t6_wrap_id", int'(ev_id), 6);
    idle(1, 1'b1);
    repeat (5) step('0, '0, 1'b1, 1'b1);
    step(4'b0001, 16'h0007, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("t6_coinc_ts", int'(ev_ts), 5);
    chk("t6_coinc_id", int'(ev_id), 7);
    idle(2, 1'b1);
    // reset with events queued and drops recorded
    do_reset();
    step(4'b0111, 16'h0123, 1'b0, 1'b0);
    step(4'b0110, 16'h0450, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t7_count", int'(fifo_count), 3);
    chk("t7_drop", int'(drop_cnt), 2);
    do_reset();
    // drop counter saturation
    repeat (80) step('1, 16'($urandom), 1'b0, 1'b0);
    chk("t8_sat", int'(drop_cnt), 255);
    // randomized traffic with alternating ready phases
    do_reset();
    for (int c = 0; c < 3000; c++)
      step(4'($urandom) & 4'($urandom), 16'($urandom), $urandom_range(0, 7) == 0,
           ((c / 200) % 2 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lif_spike_collector.md
Name: lif_spike_collector

Overview:
- Receiving end of the LIF neuron spike interface. Each lane connects to one neuron's outputs: a single-cycle spike strobe plus its spike_id.
- Captures concurrent spikes from NUM_LANES neurons and round-robin arbitrates them into an event FIFO.
- Tags each event with the current timestep and presents it as a valid/ready address-event (AER) stream to the downstream router.
- Counts spikes lost to lane contention.

Parameters:
NUM_LANES, 4, number of neuron spike lanes (2..16)
NEURON_ID_W, 4, width of spike_id per lane and of ev_id
TS_W, 8, timestep counter / tag width
FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)
DROP_W, 8, drop counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
scan_start_en  input  1  timestep boundary strobe, same signal that drives the neurons
spike_in  input  NUM_LANES  per-lane spike strobe, bit i = lane i
spike_id_in  input  NUM_LANES*NEURON_ID_W  lane i id at bits [i*NEURON_ID_W +: NEURON_ID_W]
ev_valid  output  1  head event available
ev_ready  input  1  downstream accepts head event
ev_id  output  NEURON_ID_W  head event neuron id
ev_ts  output  TS_W  head event timestep tag
fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy
drop_cnt  output  DROP_W  saturating count of dropped spikes
overflow  output  1  sticky; set on first drop, cleared only by reset

Behaviour:
- Reset (async, rst_n low):
  - Outputs: ev_valid=0, ev_id=0, ev_ts=0, fifo_count=0, drop_cnt=0, overflow=0.
  - Internal: pending flags cleared, timestep=0, round-robin pointer=0.
  - Reset mid-operation discards all pending and queued events.
- Timestep counter:
  - Increments by 1 on each cycle with scan_start_en=1.
  - Wraps from 2^TS_W-1 to 0.
- Capture:
  - When spike_in[i]=1, at the next clock edge pending[i] is set and {id, ts} is latched into lane i's holding register.
  - ts is the timestep value before any same-cycle increment. A spike coincident with scan_start_en belongs to the old timestep.
- Arbitration:
  - Combinational round-robin over the pending flags.
  - Search starts at the lane after the last granted lane; lane 0 has highest priority after reset.
  - At most one grant per cycle, issued only if the push is permitted.
  - The granted lane's pending flag is cleared at the same edge its entry is written to the FIFO.
  - The pointer advances only on a grant.
- Same-lane collision:
  - Spike on lane i while pending[i]=1 and lane i is not granted that cycle: the new spike is dropped and the held one is kept. drop_cnt += 1 (saturates at 2^DROP_W-1) and overflow is set.
  - Spike on lane i in the same cycle lane i is granted: the new spike is captured and nothing is dropped.
  - Multiple lanes dropping in one cycle each add 1 to drop_cnt; the total saturates.
- FIFO:
  - Push permitted when not full, or when full and a pop occurs the same cycle.
  - Pop occurs when ev_valid && ev_ready.
  - First-word fall-through: ev_valid = (count != 0); ev_id/ev_ts reflect the head entry.
  - ev_id/ev_ts hold stable while ev_valid=1 && ev_ready=0.
  - Push into empty with no pop: ev_valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_ready while ev_valid=0 has no effect.
- Latency:
  - Spike at cycle t, lane uncontended, FIFO not full: pending at t+1, FIFO write at the t+1 -> t+2 edge, ev_valid=1 in cycle t+2.
  - Two-cycle minimum.
- Back-pressure: while the FIFO stays full, lanes hold their pending events. Further spikes on held lanes drop; spikes on idle lanes are captured.
- Ordering: events on the same lane leave in capture order. Cross-lane order follows round-robin grant order.

Test Plan:
- Single spike: lane 2 with id 0x5 at timestep 3, ev_ready=1 -> ev_valid high exactly 2 cycles later for 1 cycle; ev_id=0x5, ev_ts=3.
- All four lanes spike together (ids 1, 2, 3, 4) from reset, ev_ready=1 -> events emitted on consecutive cycles in lane order 0, 1, 2, 3; drop_cnt=0.
- Round-robin fairness: lane 1 granted last, then lanes 0 and 3 pending -> lane 3 emitted before lane 0.
- Back-pressure and full FIFO:
  - Setup: ev_ready=0, 12 spikes spread over 4 lanes with no collisions.
  - Expected: fifo_count stops at 8 and 4 events stay pending; raising ev_ready drains all 12 in order, with no drops.
- Collision:
  - Stimulus: ev_ready=0 with FIFO full; lane 0 spikes twice while its held event is waiting.
  - Expected: drop_cnt=1, overflow=1, and only the first lane-0 id is eventually emitted.
- Timestep wrap and reset:
  - 256 scan_start_en pulses, then a spike -> ev_ts=0; a spike coincident with a scan_start_en pulse carries the pre-increment ts.
  - Asserting rst_n low with 3 events queued -> ev_valid=0, fifo_count=0, drop_cnt=0 immediately.
